// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the boot-time program loader.
package prog_loader_pkg;

  localparam int MEM_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_e;

  // Running stream checksum: plain 8-bit sum, wrapping mod 256.
  function automatic logic [BYTE_W-1:0] chk_add(input logic [BYTE_W-1:0] sum,
                                                input logic [BYTE_W-1:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, memory write port and status lines of the program loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  // master is the loader; slave is the byte source plus memory/CPU side.
  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses header/words/checksum from a byte stream, writes 16-bit
// words into main memory and holds the CPU until the image is verified.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic          clock,
  input  logic          reset,
  prog_loader_if.master bus
);

  // Number of words that fit between BASE_ADDR and the top of memory.
  localparam longint unsigned CAP = (64'd1 << ADDR_W) - 64'(BASE_ADDR);

  state_e            state_q;
  logic [BYTE_W-1:0] hi_q;
  logic [BYTE_W-1:0] sum_q;
  logic [MEM_W-1:0]  remain_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [MEM_W-1:0]  wdata_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;

  logic              ready;
  logic              accept;
  logic [MEM_W-1:0]  cnt;

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK: ready = 1'b1;
      default:                               ready = 1'b0;
    endcase
    if (reset) ready = 1'b0;
  end

  assign accept = bus.rx_valid & ready;
  assign cnt    = {hi_q, bus.rx_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= HDR_HI;
      hi_q     <= '0;
      sum_q    <= '0;
      remain_q <= '0;
      addr_q   <= ADDR_W'(BASE_ADDR);
      we_q     <= 1'b0;
      wdata_q  <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        HDR_HI: if (accept) begin
          hi_q    <= bus.rx_data;
          sum_q   <= chk_add(sum_q, bus.rx_data);
          state_q <= HDR_LO;
        end
        HDR_LO: if (accept) begin
          sum_q    <= chk_add(sum_q, bus.rx_data);
          remain_q <= cnt;
          if (cnt == '0) begin
            state_q <= CHK;
          end else if (64'(cnt) > CAP) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else begin
            state_q <= DATA_HI;
          end
        end
        DATA_HI: if (accept) begin
          hi_q    <= bus.rx_data;
          sum_q   <= chk_add(sum_q, bus.rx_data);
          state_q <= DATA_LO;
        end
        DATA_LO: if (accept) begin
          sum_q   <= chk_add(sum_q, bus.rx_data);
          wdata_q <= {hi_q, bus.rx_data};
          we_q    <= 1'b1;
          state_q <= WRITE;
        end
        // Write strobe is live this cycle; advance address for the next word.
        WRITE: begin
          addr_q   <= addr_q + 1'b1;
          remain_q <= remain_q - 1'b1;
          state_q  <= (remain_q == MEM_W'(1)) ? CHK : DATA_HI;
        end
        CHK: if (accept) begin
          if (bus.rx_data == sum_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
          end else begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end
        end
        DONE, ERR: state_q <= state_q;
      endcase
    end
  end

  assign bus.rx_ready  = ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_hold  = hold_q;
  assign bus.load_done = done_q;
  assign bus.load_err  = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (ADDR_W = 8, BASE_ADDR = 0).
module tb_prog_loader;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  int          wr_cnt;
  int          viol;
  logic        we_prev;
  logic        rst_at_edge;
  logic [7:0]  log_addr [64];
  logic [15:0] log_data [64];

  prog_loader_if #(.ADDR_W(8)) bus ();

  prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write logger plus protocol watch: strobe lasts one cycle, rx_ready low
  // while writing, and no strobe in the cycle right after a reset edge.
  initial begin
    wr_cnt = 0;
    viol = 0;
    we_prev = 1'b0;
    rst_at_edge = 1'b0;
  end
  always @(posedge clk) rst_at_edge <= rst;
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      log_addr[wr_cnt[5:0]] <= bus.mem_addr;
      log_data[wr_cnt[5:0]] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
      viol <= viol + int'(bus.rx_ready !== 1'b0) + int'(we_prev) + int'(rst_at_edge);
    end
    we_prev <= (bus.mem_we === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.rx_ready !== 1'b1) check("send_timeout", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("rst_rx_ready",  32'(bus.rx_ready),  32'd0);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_cpu_hold",  32'(bus.cpu_hold),  32'd1);
    check("rst_load_done", 32'(bus.load_done), 32'd0);
    check("rst_load_err",  32'(bus.load_err),  32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic expect_write(input string tag, input int idx, input logic [7:0] a,
                              input logic [15:0] d);
    check({tag, "_addr"}, 32'(log_addr[idx[5:0]]), 32'(a));
    check({tag, "_data"}, 32'(log_data[idx[5:0]]), 32'(d));
  endtask

  initial begin
    int base;
    logic [7:0] nominal [7];
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    nominal = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    @(negedge clk);
    do_reset();

    // Nominal back-to-back stream.
    base = wr_cnt;
    foreach (nominal[i]) send(nominal[i], 0);
    check("nom_writes", 32'(wr_cnt - base), 32'd2);
    expect_write("nom_w0", base, 8'h00, 16'h1234);
    expect_write("nom_w1", base + 1, 8'h01, 16'hABCD);
    check("nom_done", 32'(bus.load_done), 32'd1);
    check("nom_hold", 32'(bus.cpu_hold),  32'd0);
    check("nom_err",  32'(bus.load_err),  32'd0);
    check("nom_ready_after", 32'(bus.rx_ready), 32'd0);

    // Bad checksum.
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < 6; i++) send(nominal[i], 0);
    send(8'hC1, 0);
    check("bad_writes", 32'(wr_cnt - base), 32'd2);
    expect_write("bad_w0", base, 8'h00, 16'h1234);
    expect_write("bad_w1", base + 1, 8'h01, 16'hABCD);
    check("bad_err",  32'(bus.load_err),  32'd1);
    check("bad_done", 32'(bus.load_done), 32'd0);
    check("bad_hold", 32'(bus.cpu_hold),  32'd1);
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h55;
    repeat (4) @(negedge clk);
    check("bad_ready_held", 32'(bus.rx_ready), 32'd0);
    check("bad_err_sticky", 32'(bus.load_err), 32'd1);
    bus.rx_valid = 1'b0;

    // Zero length.
    do_reset();
    base = wr_cnt;
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    check("zero_writes", 32'(wr_cnt - base), 32'd0);
    check("zero_done",   32'(bus.load_done), 32'd1);
    check("zero_hold",   32'(bus.cpu_hold),  32'd0);

    // Length overflow: 257 words into a 256-word memory.
    do_reset();
    base = wr_cnt;
    send(8'h01, 0);
    send(8'h01, 0);
    check("ovf_err",    32'(bus.load_err), 32'd1);
    check("ovf_ready",  32'(bus.rx_ready), 32'd0);
    check("ovf_hold",   32'(bus.cpu_hold), 32'd1);
    repeat (3) @(negedge clk);
    check("ovf_writes", 32'(wr_cnt - base), 32'd0);

    // Nominal stream with random source gaps.
    do_reset();
    base = wr_cnt;
    foreach (nominal[i]) send(nominal[i], int'($urandom_range(0, 3)));
    check("bp_writes", 32'(wr_cnt - base), 32'd2);
    expect_write("bp_w0", base, 8'h00, 16'h1234);
    expect_write("bp_w1", base + 1, 8'h01, 16'hABCD);
    check("bp_done", 32'(bus.load_done), 32'd1);
    check("bp_err",  32'(bus.load_err),  32'd0);

    // Reset in the middle of the second word, then a fresh one-word image.
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < 5; i++) send(nominal[i], 0);
    do_reset();
    repeat (3) @(negedge clk);
    check("mid_writes", 32'(wr_cnt - base), 32'd1);
    expect_write("mid_w0", base, 8'h00, 16'h1234);
    base = wr_cnt;
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h55, 0);
    send(8'h66, 0);
    send(8'hBC, 0);
    check("mid2_writes", 32'(wr_cnt - base), 32'd1);
    expect_write("mid2_w0", base, 8'h00, 16'h5566);
    check("mid2_done", 32'(bus.load_done), 32'd1);
    check("mid2_err",  32'(bus.load_err),  32'd0);

    @(negedge clk);
    check("protocol_watch", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
